// File: rtl/msf_timing_pkg.sv
// Shared constants and types for the MSF capture-path timing generator.
package msf_timing_pkg;

  // Nominal tick rate and frame length of the capture path
  localparam int TICKS_PER_SEC  = 250;
  localparam int SECS_PER_FRAME = 16;

  // Signed phase error: wide enough for +/- TICKS_PER_SEC/2
  localparam int PERR_W = 9;

  // Tick source mode: carrier-derived or free-running from clk
  typedef enum logic {
    CARRIER  = 1'b0,
    HOLDOVER = 1'b1
  } mode_e;

  // Saturating increment used by the sync reject counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/msf_tick_source.sv
// Tick generator: divides the carrier pulse stream while pulses are present,
// and free-runs from clk once a watchdog sees the carrier go quiet.
module msf_tick_source
  import msf_timing_pkg::*;
#(
  parameter int DIV_W       = 9,
  parameter int LDIV_W      = 16,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msf_carrier_pulse,
  input  logic [DIV_W-1:0]  msf_frequency,
  input  logic [LDIV_W-1:0] local_div,
  input  logic              restart,
  output logic              tick,
  output logic              holdover,
  output logic [DIV_W-1:0]  carrier_count
);

  localparam int WD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(HOLD_CYCLES);

  mode_e             mode_r, mode_s;
  logic [WD_W-1:0]   wd_r, wd_s;
  logic [DIV_W-1:0]  ccnt_r, ccnt_s;
  logic [LDIV_W-1:0] lcnt_r, lcnt_s;
  logic              tick_r, tick_s;
  logic [DIV_W-1:0]  div_last_s;
  logic [LDIV_W-1:0] ldiv_last_s;

  // Terminal counts; a divisor of 0 behaves as 1. Comparing with >= lets a
  // divisor lowered below the running count wrap on the next event.
  always_comb begin
    div_last_s  = {DIV_W{1'b0}};
    ldiv_last_s = {LDIV_W{1'b0}};
    if (msf_frequency != {DIV_W{1'b0}}) begin
      div_last_s = msf_frequency - 1'b1;
    end else begin
      div_last_s = {DIV_W{1'b0}};
    end
    if (local_div != {LDIV_W{1'b0}}) begin
      ldiv_last_s = local_div - 1'b1;
    end else begin
      ldiv_last_s = {LDIV_W{1'b0}};
    end
  end

  // Mode FSM, watchdog and both dividers. Any mode change restarts both
  // dividers without producing a tick; a pulse always beats the watchdog.
  always_comb begin
    mode_s = mode_r;
    wd_s   = wd_r;
    ccnt_s = ccnt_r;
    lcnt_s = lcnt_r;
    tick_s = 1'b0;
    if (msf_carrier_pulse) begin
      wd_s = {WD_W{1'b0}};
      case (mode_r)
        HOLDOVER: begin
          mode_s = CARRIER;
          ccnt_s = {DIV_W{1'b0}};
          lcnt_s = {LDIV_W{1'b0}};
        end
        CARRIER: begin
          if (restart) begin
            ccnt_s = {DIV_W{1'b0}};
          end else if (ccnt_r >= div_last_s) begin
            ccnt_s = {DIV_W{1'b0}};
            tick_s = 1'b1;
          end else begin
            ccnt_s = ccnt_r + 1'b1;
          end
        end
        default: begin
          mode_s = HOLDOVER;
          ccnt_s = {DIV_W{1'b0}};
          lcnt_s = {LDIV_W{1'b0}};
        end
      endcase
    end else begin
      if (wd_r != WD_MAX) begin
        wd_s = wd_r + 1'b1;
      end else begin
        wd_s = wd_r;
      end
      case (mode_r)
        CARRIER: begin
          if (wd_s == WD_MAX) begin
            mode_s = HOLDOVER;
            ccnt_s = {DIV_W{1'b0}};
            lcnt_s = {LDIV_W{1'b0}};
          end else if (restart) begin
            ccnt_s = {DIV_W{1'b0}};
          end else begin
            ccnt_s = ccnt_r;
          end
        end
        HOLDOVER: begin
          if (restart) begin
            lcnt_s = {LDIV_W{1'b0}};
          end else if (lcnt_r >= ldiv_last_s) begin
            lcnt_s = {LDIV_W{1'b0}};
            tick_s = 1'b1;
          end else begin
            lcnt_s = lcnt_r + 1'b1;
          end
        end
        default: begin
          mode_s = HOLDOVER;
          ccnt_s = {DIV_W{1'b0}};
          lcnt_s = {LDIV_W{1'b0}};
        end
      endcase
    end
  end

  // State register; comes out of reset in holdover awaiting the carrier
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r <= HOLDOVER;
      wd_r   <= {WD_W{1'b0}};
      ccnt_r <= {DIV_W{1'b0}};
      lcnt_r <= {LDIV_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      mode_r <= mode_s;
      wd_r   <= wd_s;
      ccnt_r <= ccnt_s;
      lcnt_r <= lcnt_s;
      tick_r <= tick_s;
    end
  end

  assign tick          = tick_r;
  assign holdover      = (mode_r == HOLDOVER);
  assign carrier_count = ccnt_r;

endmodule

// File: rtl/msf_timing_control_p.sv
// Timing generator for the MSF capture path: sub-second, second-slot and
// BRAM address counters driven by the tick source, with windowed phase
// re-alignment to the demodulated MSF second edge.
module msf_timing_control_p #(
  parameter int DIV_W          = 9,
  parameter int TICKS_PER_SEC  = msf_timing_pkg::TICKS_PER_SEC,
  parameter int SECS_PER_FRAME = msf_timing_pkg::SECS_PER_FRAME,
  parameter int ADDR_W         = 12,
  parameter int SLOT_W         = 4,
  parameter int LDIV_W         = 16,
  parameter int HOLD_CYCLES    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msf_carrier_pulse,
  input  logic [DIV_W-1:0]  msf_frequency,
  input  logic [LDIV_W-1:0] local_div,
  input  logic              sec_sync,
  input  logic              sync_en,
  input  logic [7:0]        sync_window,
  output logic [ADDR_W-1:0] address_counter,
  output logic [DIV_W-1:0]  msf_carrier_counter,
  output logic [7:0]        second_tick_counter,
  output logic              one_sec_marker,
  output logic [SLOT_W-1:0] write_second_bram,
  output logic              tick,
  output logic              holdover,
  output logic [8:0]        phase_error,
  output logic [7:0]        sync_reject_count
);

  import msf_timing_pkg::*;

  localparam logic [7:0]        SEC_LAST  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0]        SEC_HALF  = 8'(TICKS_PER_SEC / 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SECS_PER_FRAME - 1);

  logic [7:0]               sec_r, sec_s;
  logic [SLOT_W-1:0]        slot_r, slot_s;
  logic [ADDR_W-1:0]        addr_r, addr_s;
  logic                     marker_r, marker_s;
  logic signed [PERR_W-1:0] perr_r, perr_s;
  logic [7:0]               rej_r, rej_s;
  logic signed [PERR_W-1:0] err_s;
  logic [PERR_W-1:0]        err_mag_s;
  logic                     accept_s;
  logic [SLOT_W-1:0]        slot_inc_s;
  logic                     tick_s;

  msf_tick_source #(
    .DIV_W       (DIV_W),
    .LDIV_W      (LDIV_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_tick_source (
    .clk               (clk),
    .rst               (rst),
    .msf_carrier_pulse (msf_carrier_pulse),
    .msf_frequency     (msf_frequency),
    .local_div         (local_div),
    .restart           (accept_s),
    .tick              (tick_s),
    .holdover          (holdover),
    .carrier_count     (msf_carrier_counter)
  );

  // Phase error of the current position relative to the nearest second edge
  always_comb begin
    err_s     = {PERR_W{1'b0}};
    err_mag_s = {PERR_W{1'b0}};
    accept_s  = 1'b0;
    if (sec_r < SEC_HALF) begin
      err_s = $signed(PERR_W'(sec_r));
    end else begin
      err_s = $signed(PERR_W'(sec_r)) - $signed(PERR_W'(TICKS_PER_SEC));
    end
    if (err_s < 0) begin
      err_mag_s = PERR_W'(-err_s);
    end else begin
      err_mag_s = PERR_W'(err_s);
    end
    accept_s = sec_sync & sync_en & (err_mag_s <= PERR_W'(sync_window));
  end

  // Next counter values; an accepted sync overrides a coincident tick
  always_comb begin
    sec_s    = sec_r;
    slot_s   = slot_r;
    marker_s = 1'b0;
    perr_s   = perr_r;
    rej_s    = rej_r;
    addr_s   = addr_r;
    if (slot_r == SLOT_LAST) begin
      slot_inc_s = {SLOT_W{1'b0}};
    end else begin
      slot_inc_s = slot_r + 1'b1;
    end
    if (accept_s) begin
      perr_s = err_s;
      sec_s  = 8'd0;
      if (err_s < 0) begin
        slot_s   = slot_inc_s;
        marker_s = 1'b1;
      end else begin
        slot_s   = slot_r;
      end
    end else if (tick_s) begin
      if (sec_r >= SEC_LAST) begin
        sec_s    = 8'd0;
        slot_s   = slot_inc_s;
        marker_s = 1'b1;
      end else begin
        sec_s    = sec_r + 1'b1;
      end
    end else begin
      sec_s = sec_r;
    end
    if (sec_sync && sync_en && !accept_s) begin
      rej_s = sat_inc8(rej_r);
    end else begin
      rej_s = rej_r;
    end
    addr_s = ADDR_W'(slot_s) * ADDR_W'(TICKS_PER_SEC) + ADDR_W'(sec_s);
  end

  // Counter registers; address is registered alongside the counters it encodes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_r    <= 8'd0;
      slot_r   <= {SLOT_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      marker_r <= 1'b0;
      perr_r   <= {PERR_W{1'b0}};
      rej_r    <= 8'd0;
    end else begin
      sec_r    <= sec_s;
      slot_r   <= slot_s;
      addr_r   <= addr_s;
      marker_r <= marker_s;
      perr_r   <= perr_s;
      rej_r    <= rej_s;
    end
  end

  assign address_counter     = addr_r;
  assign second_tick_counter = sec_r;
  assign write_second_bram   = slot_r;
  assign one_sec_marker      = marker_r;
  assign phase_error         = perr_r;
  assign sync_reject_count   = rej_r;
  assign tick                = tick_s;

endmodule

// File: tb/tb_msf_timing_control_p.sv
// Self-checking bench: random carrier/holdover/sync stimulus compared every
// cycle against a tick-position reference model, plus directed spot checks.
module tb_msf_timing_control_p;

  localparam int TPS   = 250;
  localparam int SPF   = 16;
  localparam int FRAME = TPS * SPF;
  localparam int HOLD  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        msf_carrier_pulse = 1'b0;
  logic [8:0]  msf_frequency = 9'd1;
  logic [15:0] local_div = 16'd1;
  logic        sec_sync = 1'b0;
  logic        sync_en = 1'b0;
  logic [7:0]  sync_window = 8'd0;
  logic [11:0] address_counter;
  logic [8:0]  msf_carrier_counter;
  logic [7:0]  second_tick_counter;
  logic        one_sec_marker;
  logic [3:0]  write_second_bram;
  logic        tick;
  logic        holdover;
  logic [8:0]  phase_error;
  logic [7:0]  sync_reject_count;

  msf_timing_control_p #(.HOLD_CYCLES(HOLD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .msf_carrier_pulse   (msf_carrier_pulse),
    .msf_frequency       (msf_frequency),
    .local_div           (local_div),
    .sec_sync            (sec_sync),
    .sync_en             (sync_en),
    .sync_window         (sync_window),
    .address_counter     (address_counter),
    .msf_carrier_counter (msf_carrier_counter),
    .second_tick_counter (second_tick_counter),
    .one_sec_marker      (one_sec_marker),
    .write_second_bram   (write_second_bram),
    .tick                (tick),
    .holdover            (holdover),
    .phase_error         (phase_error),
    .sync_reject_count   (sync_reject_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: position within the frame as a single tick index
  int m_total, m_marker, m_perr, m_rej;
  int m_hold, m_wd, m_cc, m_lc, m_tick;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_total = 0; m_marker = 0; m_perr = 0; m_rej = 0;
    m_hold = 1; m_wd = 0; m_cc = 0; m_lc = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit p, input bit s);
    int sec, err, mag;
    bit acc;
    sec = m_total % TPS;
    err = (sec < TPS / 2) ? sec : sec - TPS;
    mag = (err < 0) ? -err : err;
    acc = s && sync_en && (mag <= int'(sync_window));
    m_marker = 0;
    if (acc) begin
      m_perr = err;
      if (err < 0) begin
        m_total = (((m_total / TPS) + 1) * TPS) % FRAME;
        m_marker = 1;
      end else begin
        m_total = (m_total / TPS) * TPS;
      end
    end else if (m_tick == 1) begin
      m_total = (m_total + 1) % FRAME;
      m_marker = (m_total % TPS == 0) ? 1 : 0;
    end
    if (s && sync_en && !acc && m_rej < 255) m_rej++;
    m_tick = 0;
    if (p) begin
      m_wd = 0;
      if (m_hold == 1) begin
        m_hold = 0; m_cc = 0; m_lc = 0;
      end else if (acc) begin
        m_cc = 0;
      end else begin
        m_cc++;
        if (m_cc >= eff(int'(msf_frequency))) begin m_cc = 0; m_tick = 1; end
      end
    end else begin
      if (m_wd < HOLD) m_wd++;
      if (m_hold == 0) begin
        if (m_wd == HOLD) begin
          m_hold = 1; m_cc = 0; m_lc = 0;
        end else if (acc) begin
          m_cc = 0;
        end
      end else if (acc) begin
        m_lc = 0;
      end else begin
        m_lc++;
        if (m_lc >= eff(int'(local_div))) begin m_lc = 0; m_tick = 1; end
      end
    end
  endtask

  task automatic check_all();
    check("address", address_counter, m_total);
    check("sec", second_tick_counter, m_total % TPS);
    check("slot", write_second_bram, m_total / TPS);
    check("marker", one_sec_marker, m_marker);
    check("tick", tick, m_tick);
    check("holdover", holdover, m_hold);
    check("carrier_cnt", msf_carrier_counter, m_cc);
    check("phase_err", $signed(phase_error), m_perr);
    check("rej", sync_reject_count, m_rej);
  endtask

  task automatic step(input bit p, input bit s);
    msf_carrier_pulse = p;
    sec_sync = s;
    @(posedge clk);
    model_edge(p, s);
    @(negedge clk);
    msf_carrier_pulse = 1'b0;
    sec_sync = 1'b0;
    check_all();
  endtask

  task automatic run_until_sec(input int target, input bit p);
    int n = 0;
    while ((m_total % TPS) != target && n < 2000) begin
      step(p, 1'b0);
      n++;
    end
    check("reach_sec", second_tick_counter, target);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, address_counter, 0);
    check({tag, "_sec"}, second_tick_counter, 0);
    check({tag, "_slot"}, write_second_bram, 0);
    check({tag, "_marker"}, one_sec_marker, 0);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_hold"}, holdover, 1);
    check({tag, "_cc"}, msf_carrier_counter, 0);
    check({tag, "_perr"}, phase_error, 0);
    check({tag, "_rej"}, sync_reject_count, 0);
  endtask

  initial begin
    int slot_before, rej_before;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    // Carrier mode, varying divisor (including 0 and runtime lowering)
    for (int i = 0; i < 16000; i++) begin
      if (i % 97 == 0) msf_frequency = 9'($urandom_range(0, 3));
      step(($urandom_range(0, 7) != 0), 1'b0);
    end

    // Carrier loss: holdover after the watchdog limit, then free-run
    local_div = 16'd3;
    for (int i = 0; i < HOLD; i++) step(1'b0, 1'b0);
    check("hold_entered", holdover, 1);
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) local_div = 16'($urandom_range(0, 6));
      step(1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    check("hold_exit", holdover, 0);
    check("hold_exit_cc", msf_carrier_counter, 0);

    // Directed sync re-alignment with a tick on every pulse
    msf_frequency = 9'd1;
    sync_en = 1'b1;
    sync_window = 8'd5;
    run_until_sec(3, 1'b1);
    slot_before = m_total / TPS;
    step(1'b1, 1'b1);
    check("sync3_perr", $signed(phase_error), 3);
    check("sync3_sec", second_tick_counter, 0);
    check("sync3_slot", write_second_bram, slot_before);
    check("sync3_marker", one_sec_marker, 0);

    run_until_sec(247, 1'b1);
    slot_before = m_total / TPS;
    step(1'b1, 1'b1);
    check("sync247_perr", $signed(phase_error), -3);
    check("sync247_sec", second_tick_counter, 0);
    check("sync247_slot", write_second_bram, (slot_before + 1) % SPF);
    check("sync247_marker", one_sec_marker, 1);

    run_until_sec(100, 1'b1);
    rej_before = m_rej;
    step(1'b0, 1'b1);
    check("sync100_rej", sync_reject_count, rej_before + 1);
    check("sync100_perr", $signed(phase_error), -3);

    // sync_en low: sec_sync ignored
    sync_en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("sync_dis_rej", sync_reject_count, rej_before + 1);

    // Saturating reject counter with ticks stalled
    sync_en = 1'b1;
    sync_window = 8'd0;
    local_div = 16'hFFFF;
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    check("rej_sat", sync_reject_count, 255);

    // Random mix of carrier gaps, divisors and syncs
    for (int i = 0; i < 5000; i++) begin
      if (i % 200 == 0) begin
        msf_frequency = 9'($urandom_range(0, 4));
        local_div = 16'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 49) == 0) begin
        sync_en = 1'($urandom_range(0, 3) != 0);
        sync_window = 8'($urandom_range(0, 130));
        step(($urandom_range(0, 3) != 0), 1'b1);
      end else if ((i % 1000) >= 900 && (i % 1000) < 960) begin
        step(1'b0, 1'b0);
      end else begin
        step(($urandom_range(0, 3) != 0), 1'b0);
      end
    end

    // Asynchronous reset mid-frame
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b1;
    msf_frequency = 9'd2;
    for (int i = 0; i < 300; i++) step(($urandom_range(0, 3) != 0), 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/msf_timing_control_p.md
Name: msf_timing_control_p

Overview:
Parametrised second-generation timing generator for the MSF capture path. It divides the MSF carrier pulse stream into a tick rate of TICKS_PER_SEC ticks per second, and produces the sub-second, second-slot and BRAM write-address counters for a frame of SECS_PER_FRAME seconds. It adds two behaviours: a holdover mode that free-runs from the local clock when carrier pulses stop, and windowed phase re-alignment to a demodulated MSF second-edge pulse. It sits between the carrier detector and the sample BRAM writer.

Parameters:
DIV_W, 9, width of the carrier divisor and carrier counter
TICKS_PER_SEC, 250, ticks per second
SECS_PER_FRAME, 16, seconds per BRAM frame (power of two)
ADDR_W, 12, address width; must satisfy 2**ADDR_W >= TICKS_PER_SEC*SECS_PER_FRAME
SLOT_W, 4, width of log2(SECS_PER_FRAME)
LDIV_W, 16, width of the local divider
HOLD_CYCLES, 1000, clk cycles without a carrier pulse before holdover is entered

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
msf_carrier_pulse  in  1  one-cycle carrier pulse
msf_frequency  in  DIV_W  carrier pulses per tick
local_div  in  LDIV_W  clk cycles per tick while in holdover
sec_sync  in  1  one-cycle demodulated MSF second edge
sync_en  in  1  enables re-alignment
sync_window  in  8  maximum |phase error| in ticks that is accepted
address_counter  out  ADDR_W  0..TICKS_PER_SEC*SECS_PER_FRAME-1
msf_carrier_counter  out  DIV_W  carrier pulses counted in the current tick
second_tick_counter  out  8  0..TICKS_PER_SEC-1
one_sec_marker  out  1  one-cycle pulse at each second boundary
write_second_bram  out  SLOT_W  current second slot
tick  out  1  one-cycle tick strobe
holdover  out  1  1 while free-running from the local clock
phase_error  out  9  signed tick offset latched at the last accepted sync
sync_reject_count  out  8  saturating count of rejected syncs

Behaviour:
- Reset (rst=0, asynchronous): every counter and output is 0, except holdover, which is 1. The block starts in holdover until the first carrier pulse arrives.
- Tick source, carrier mode:
  - On each pulse, msf_carrier_counter increments.
  - On the pulse where the counter equals msf_frequency-1, the counter wraps to 0 and tick asserts in the next cycle (latency 1).
  - msf_frequency of 0 or 1 gives a tick on every pulse.
- Tick source, holdover mode:
  - A local counter counts clk cycles from 0 to local_div-1; on wrap, tick asserts. local_div of 0 is treated as 1.
- Mode control:
  - A watchdog counts clk cycles since the last pulse, saturating at HOLD_CYCLES. Reaching HOLD_CYCLES sets holdover=1.
  - Any pulse clears holdover and the watchdog.
  - On every mode change, both the local and carrier counters restart at 0.
  - Sub-second and slot counters continue across mode changes without any jump.
- Counting on tick:
  - second_tick_counter increments.
  - On wrap from TICKS_PER_SEC-1 to 0: one_sec_marker=1 for exactly the tick cycle, and write_second_bram increments, wrapping at SECS_PER_FRAME-1.
  - address_counter = slot*TICKS_PER_SEC + second_tick_counter at all times, registered together with the counters. It wraps from TICKS_PER_SEC*SECS_PER_FRAME-1 to 0.
- Sync re-alignment (sec_sync=1 with sync_en=1):
  - err = second_tick_counter if second_tick_counter < TICKS_PER_SEC/2, else second_tick_counter - TICKS_PER_SEC (signed).
  - If |err| <= sync_window: phase_error=err. Next cycle, second_tick_counter=0 and the carrier/local counter=0. If err<0 the slot advances and one_sec_marker pulses; if err>=0 the slot holds and no marker pulses.
  - Otherwise sync_reject_count increments, saturating at 255, and the counters are untouched.
  - With sync_en=0, sec_sync is ignored.
- Simultaneous events:
  - Accepted sync coincident with tick: sync wins, and the tick's increment is discarded.
  - Pulse coincident with the watchdog reaching its limit: the pulse wins, and holdover stays 0.
- Runtime input changes: msf_frequency and local_div are sampled continuously. Lowering either below the current count causes a wrap on the next pulse or cycle; the counter never runs through 2**W.

Decomposition:
- msf_timing_pkg: TICKS_PER_SEC, SECS_PER_FRAME, the phase_error width, and the mode enum (CARRIER, HOLDOVER).
- One sub-module, msf_tick_source: the carrier divider, local divider, watchdog and mode FSM, producing tick and holdover.
- Top level: the second/slot/address counters and the sync logic.

Test Plan:
- Pulse every 165 clks, msf_frequency=310 -> tick every 51150 clks; one_sec_marker every 250 ticks; address_counter runs 0..3999 and wraps to 0 as the slot goes 15 -> 0.
- Stop pulses for 1000 clks with local_div=50000 -> holdover=1 at watchdog limit, ticks every 50000 clks, no counter jump; first pulse after that -> holdover=0, carrier counter restarts at 0.
- sec_sync at second_tick_counter=3, sync_window=5 -> phase_error=+3, counter=0, slot unchanged, no marker.
- sec_sync at second_tick_counter=247 -> phase_error=-3, slot+1, one_sec_marker pulses; sync at 100 with sync_window=5 -> sync_reject_count+1, counters untouched.
- Sync coincident with tick -> second_tick_counter=0, not 1; 300 rejected syncs -> sync_reject_count=255.
- Assert rst=0 mid-frame, asynchronous to clk -> all outputs immediately 0 except holdover=1; release -> counting resumes from 0.
